// File: rtl/servo_pkg.sv
// Purpose: shared constants, derived centre position and request-priority type for the servo PWM block.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package servo_pkg;

  // Defaults: 100 MHz clock, 20 ms frame, pulse width 1..2 ms, 10 us per step
  localparam int DEF_PERIOD_CYCLES = 2000000;
  localparam int DEF_PULSE_MIN     = 100000;
  localparam int DEF_PULSE_MAX     = 200000;
  localparam int DEF_STEP          = 1000;
  localparam int DEF_POS_W         = 21;
  localparam int DEF_IDLE_FRAMES   = 50;

  // Neutral servo position: midpoint of the legal pulse range, rounded down
  function automatic int calc_center(input int pulse_min, input int pulse_max);
    return (pulse_min + pulse_max) / 2;
  endfunction

  localparam int DEF_PCENTER = calc_center(DEF_PULSE_MIN, DEF_PULSE_MAX);

  // Outcome of the requests accumulated over one frame
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_CENTER,
    REQ_LEFT,
    REQ_RIGHT,
    REQ_CONFLICT
  } req_t;

  // Centre beats everything; left and right together cancel out
  function automatic req_t req_decode(input logic c, input logic l, input logic r);
    req_t v;
    if (c)           v = REQ_CENTER;
    else if (l && r) v = REQ_CONFLICT;
    else if (l)      v = REQ_LEFT;
    else if (r)      v = REQ_RIGHT;
    else             v = REQ_NONE;
    return v;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Purpose: free-running PWM frame counter 0..PERIOD_CYCLES-1 with a last-cycle marker.
// Latency: o_frame_end is decoded from the counter register in the same cycle.
// Backpressure: none; the counter never stalls, synchronous reset restarts it at 0.
module servo_frame_timer #(
  parameter int PERIOD_CYCLES = servo_pkg::DEF_PERIOD_CYCLES,
  parameter int POS_W         = servo_pkg::DEF_POS_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [POS_W-1:0] o_period_cnt,
  output logic             o_frame_end
);

  localparam logic [POS_W-1:0] LP_LAST = POS_W'(PERIOD_CYCLES - 1);

  logic [POS_W-1:0] r_period_cnt;
  logic             w_last;

  assign w_last = (r_period_cnt == LP_LAST);

  // Count through the frame and wrap after the last cycle
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_period_cnt <= '0;
    else if (w_last) r_period_cnt <= '0;
    else             r_period_cnt <= r_period_cnt + POS_W'(1);
  end

  assign o_period_cnt = r_period_cnt;
  assign o_frame_end  = w_last;

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Purpose: per-axis servo position register and fixed-period PWM; optional idle blanking under SERVO_PWM_IDLE_EN.
// Latency: PWM is one cycle behind the frame counter; POS and limit flags change the cycle after FRAME_END.
// Backpressure: none; step requests are levels OR-ed into sticky flags and all are accepted at frame end.
module servo_pwm_ctrl import servo_pkg::*; #(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int PULSE_MIN     = DEF_PULSE_MIN,
  parameter int PULSE_MAX     = DEF_PULSE_MAX,
  parameter int STEP          = DEF_STEP,
  parameter int POS_W         = DEF_POS_W
`ifdef SERVO_PWM_IDLE_EN
  ,
  parameter int IDLE_FRAMES   = DEF_IDLE_FRAMES
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CNT_L,
  input  logic             CNT_R,
  input  logic             CENTER,
  output logic             PWM,
  output logic [POS_W-1:0] POS,
  output logic             AT_MIN,
  output logic             AT_MAX,
  output logic             PWM_limit,
  output logic             FRAME_END
);

  localparam int PCENTER = calc_center(PULSE_MIN, PULSE_MAX);

  localparam logic [POS_W-1:0] LP_CENTER = POS_W'(PCENTER);
  localparam logic [POS_W-1:0] LP_MIN    = POS_W'(PULSE_MIN);
  localparam logic [POS_W-1:0] LP_MAX    = POS_W'(PULSE_MAX);

  // One extra sign bit so POS-STEP below zero cannot wrap to a large value
  localparam logic signed [POS_W:0] LP_STEP_S = (POS_W+1)'(STEP);
  localparam logic signed [POS_W:0] LP_MIN_S  = (POS_W+1)'(PULSE_MIN);
  localparam logic signed [POS_W:0] LP_MAX_S  = (POS_W+1)'(PULSE_MAX);

  logic [POS_W-1:0]        w_period_cnt;
  logic                    w_frame_end;
  logic                    w_req_l;
  logic                    w_req_r;
  logic                    w_req_c;
  req_t                    w_req;
  logic signed [POS_W:0]   w_pos_dec_s;
  logic signed [POS_W:0]   w_pos_inc_s;
  logic [POS_W-1:0]        w_pos_nxt;
  logic                    w_pwm_en;

  logic                    r_req_l;
  logic                    r_req_r;
  logic                    r_req_c;
  logic [POS_W-1:0]        r_pos;
  logic [POS_W-1:0]        r_active_width;
  logic                    r_at_min;
  logic                    r_at_max;
  logic                    r_limit;
  logic                    r_pwm;

  servo_frame_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .POS_W         (POS_W)
  ) u_frame_timer (
    .i_clk        (CLK),
    .i_rst        (RST),
    .o_period_cnt (w_period_cnt),
    .o_frame_end  (w_frame_end)
  );

  // A request arriving in the FRAME_END cycle itself still belongs to this frame
  assign w_req_l = r_req_l | CNT_L;
  assign w_req_r = r_req_r | CNT_R;
  assign w_req_c = r_req_c | CENTER;
  assign w_req   = req_decode(w_req_c, w_req_l, w_req_r);

  assign w_pos_dec_s = $signed({1'b0, r_pos}) - LP_STEP_S;
  assign w_pos_inc_s = $signed({1'b0, r_pos}) + LP_STEP_S;

  // Candidate position for this frame's commit, saturated at both ends of the range
  always_comb begin
    w_pos_nxt = r_pos;
    case (w_req)
      REQ_CENTER: w_pos_nxt = LP_CENTER;
      REQ_LEFT:   w_pos_nxt = (w_pos_dec_s < LP_MIN_S) ? LP_MIN : w_pos_dec_s[POS_W-1:0];
      REQ_RIGHT:  w_pos_nxt = (w_pos_inc_s > LP_MAX_S) ? LP_MAX : w_pos_inc_s[POS_W-1:0];
      default:    w_pos_nxt = r_pos;
    endcase
  end

  // Sticky request flags, emptied at every frame boundary so nothing carries over
  always_ff @(posedge CLK) begin
    if (RST || w_frame_end) begin
      r_req_l <= 1'b0;
      r_req_r <= 1'b0;
      r_req_c <= 1'b0;
    end else begin
      r_req_l <= w_req_l;
      r_req_r <= w_req_r;
      r_req_c <= w_req_c;
    end
  end

  // Commit position and pulse width together only at frame end, so a pulse is never cut or stretched
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pos          <= LP_CENTER;
      r_active_width <= LP_CENTER;
      r_at_min       <= (LP_CENTER == LP_MIN);
      r_at_max       <= (LP_CENTER == LP_MAX);
      r_limit        <= (LP_CENTER != LP_MIN) && (LP_CENTER != LP_MAX);
    end else if (w_frame_end) begin
      r_pos          <= w_pos_nxt;
      r_active_width <= w_pos_nxt;
      r_at_min       <= (w_pos_nxt == LP_MIN);
      r_at_max       <= (w_pos_nxt == LP_MAX);
      r_limit        <= (w_pos_nxt != LP_MIN) && (w_pos_nxt != LP_MAX);
    end
  end

`ifdef SERVO_PWM_IDLE_EN
  localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
  localparam logic [IDLE_W-1:0] LP_IDLE_MAX  = IDLE_W'(IDLE_FRAMES);
  localparam logic [IDLE_W-1:0] LP_IDLE_LAST = IDLE_W'(IDLE_FRAMES - 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_idle;

  // Count consecutive request-free frames; blank the output once the threshold is reached
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idle_cnt <= '0;
      r_idle     <= 1'b0;
    end else if (w_frame_end) begin
      if (w_req != REQ_NONE) begin
        r_idle_cnt <= '0;
        r_idle     <= 1'b0;
      end else if (r_idle_cnt != LP_IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        if (r_idle_cnt == LP_IDLE_LAST) r_idle <= 1'b1;
      end
    end
  end

  assign w_pwm_en = ~r_idle;
`else
  assign w_pwm_en = 1'b1;
`endif

  // Registered pulse: high while the frame counter is below the committed width
  always_ff @(posedge CLK) begin
    if (RST) r_pwm <= 1'b0;
    else     r_pwm <= w_pwm_en & (w_period_cnt < r_active_width);
  end

  assign PWM       = r_pwm;
  assign POS       = r_pos;
  assign AT_MIN    = r_at_min;
  assign AT_MAX    = r_at_max;
  assign PWM_limit = r_limit;
  assign FRAME_END = w_frame_end;

endmodule

// File: doc/servo_pwm_ctrl.md
Name: servo_pwm_ctrl

Overview:
- Downstream consumer of the horizontal/vertical sweep counters' step enables (CNT_L / CNT_R).
- Holds the servo position register and generates the fixed-period servo PWM.
- Reports limit status back to the sweep FSM and counters via PWM_limit, AT_MIN and AT_MAX.
- One instance per axis.

Parameters:
- PERIOD_CYCLES, 2000000, PWM frame length in CLK cycles (20 ms @ 100 MHz).
- PULSE_MIN, 100000, minimum pulse width in cycles (1 ms).
- PULSE_MAX, 200000, maximum pulse width in cycles (2 ms).
- STEP, 1000, position change per accepted step request, in cycles.
- POS_W, 21, width of the period counter and position; must hold PERIOD_CYCLES-1.
- IDLE_FRAMES, 50, frames without request before PWM idle (optional feature only).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- CNT_L  in  1  step-left request, level (decrease position)
- CNT_R  in  1  step-right request, level (increase position)
- CENTER  in  1  recentre request, level; highest priority
- PWM  out  1  servo pulse output, registered
- POS  out  POS_W  current committed position (pulse width in cycles)
- AT_MIN  out  1  POS == PULSE_MIN
- AT_MAX  out  1  POS == PULSE_MAX
- PWM_limit  out  1  headroom flag = ~AT_MIN & ~AT_MAX
- FRAME_END  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset is synchronous, active-high, on CLK.
- On reset:
  - period_cnt = 0.
  - POS = active_width = PCENTER, where PCENTER = (PULSE_MIN+PULSE_MAX)/2, floor.
  - PWM = 0, FRAME_END = 0.
  - Request flags cleared.
  - AT_MIN, AT_MAX and PWM_limit reflect PCENTER (0, 0, 1 for valid parameters).
- Period counter:
  - Counts 0..PERIOD_CYCLES-1, then wraps to 0.
  - FRAME_END = 1 in the cycle period_cnt == PERIOD_CYCLES-1.
- PWM:
  - PWM <= (period_cnt < active_width). One cycle latency from the counter.
  - In the first cycle after reset release, PWM = 0; it goes high the next cycle.
- Request capture:
  - Sticky flags req_l, req_r and req_c OR in CNT_L, CNT_R and CENTER on every cycle of the frame, including the FRAME_END cycle.
  - All flags clear at FRAME_END. A request present in the FRAME_END cycle counts for the current frame and is not carried over.
- Commit at FRAME_END, in priority order:
  - req_c: POS <= PCENTER.
  - else req_l & req_r: no change (conflict).
  - else req_l: POS <= max(POS-STEP, PULSE_MIN). Compute with a POS_W+1-bit signed intermediate; no underflow wrap.
  - else req_r: POS <= min(POS+STEP, PULSE_MAX). No overflow.
  - else: hold.
  - active_width <= the new POS in the same cycle, so the new width applies from the next frame's period_cnt = 0. The pulse width never changes mid-frame (no runt or stretched pulses).
- Outputs AT_MIN, AT_MAX and PWM_limit are registered from POS and update in the cycle after a commit.
- A request while already at the limit in that direction is accepted; POS stays saturated.
- Reset mid-frame: immediate restart at period_cnt = 0 with PCENTER; pending flags are discarded.

Optional Feature:
- Macro: SERVO_PWM_IDLE_EN.
- Defined:
  - An idle_cnt counts consecutive frames that commit with no request flag set.
  - When idle_cnt reaches IDLE_FRAMES, PWM is forced to 0 from the next frame on, but period_cnt keeps running.
  - Any request flag seen at FRAME_END clears idle_cnt and re-enables PWM from the next frame.
  - Reset clears idle_cnt.
- Not defined: PWM is always active. Idle logic is absent and POS behaviour is identical.

Decomposition:
- Shared package servo_pkg holds:
  - default constants PERIOD_CYCLES, PULSE_MIN, PULSE_MAX, STEP, IDLE_FRAMES;
  - derived PCENTER;
  - a request-priority enum (REQ_NONE, REQ_CENTER, REQ_LEFT, REQ_RIGHT, REQ_CONFLICT).
- One sub-module is natural: servo_frame_timer, containing period_cnt and FRAME_END generation, parameterised by PERIOD_CYCLES and POS_W.

Test Plan (params PERIOD_CYCLES=100, PULSE_MIN=10, PULSE_MAX=20, STEP=2, POS_W=8, so PCENTER=15):
- Reset then idle 3 frames -> PWM high exactly 15 cycles per 100-cycle frame; POS=15; PWM_limit=1; FRAME_END every 100th cycle.
- CNT_L pulsed for 1 cycle mid-frame -> POS=13 at the next FRAME_END; the following frame's pulse is 13 cycles; the current frame's pulse stays 15 cycles.
- CNT_R held high for 4 frames from POS=15 -> POS goes 17, 19, 20, 20; AT_MAX=1 and PWM_limit=0 after the third commit.
- CNT_L and CNT_R both asserted in one frame -> POS unchanged. CENTER together with CNT_L at POS=11 -> POS=15.
- Assert RST at period_cnt=40 with POS=19 -> next cycle period_cnt=0, POS=15, PWM=0, pending request discarded.
- With SERVO_PWM_IDLE_EN and IDLE_FRAMES=2:
  - 2 request-free frames -> PWM stays 0 from the 3rd frame onward.
  - A single CNT_R pulse -> POS=17, and PWM resumes with a 17-cycle pulse in the next frame.
